// File: rtl/seven_seg_capture.sv
// Loopback monitor for a multiplexed active-low seven-segment bus: waits for each
// anode/segment pattern to settle, inverse-decodes it and stores the digit per position.
// Optional `define SEVEN_SEG_CAPTURE_ERR_EN enables the sticky pattern_err flag.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [IDX_W-1:0]        upd_index,
    output logic                    pattern_err
);

    localparam int BUS_W = NUM_DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [BUS_W-1:0] sync1;
    logic [BUS_W-1:0] sync2;
    logic [BUS_W-1:0] prev;
    logic             changed;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;

    logic [NUM_DIGITS-1:0] an_low;
    logic                  one_hot;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            dec_value;
    logic                  dec_valid;
    logic                  capture_go;

    // Both synchronizer stages idle as "no anode active, blank".
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {an, seg};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign changed = (sync2 != prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (changed) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign an_low  = ~sync2[BUS_W-1:7];
    assign one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);

    // NOTE: every signal written in always_comb gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        dec_value = 4'hE;
        dec_valid = 1'b0;
        case (sync2[6:0])
            7'b1000000: begin dec_value = 4'd0; dec_valid = 1'b1; end
            7'b1111001: begin dec_value = 4'd1; dec_valid = 1'b1; end
            7'b0100100: begin dec_value = 4'd2; dec_valid = 1'b1; end
            7'b0110000: begin dec_value = 4'd3; dec_valid = 1'b1; end
            7'b0011001: begin dec_value = 4'd4; dec_valid = 1'b1; end
            7'b0010010: begin dec_value = 4'd5; dec_valid = 1'b1; end
            7'b0000010: begin dec_value = 4'd6; dec_valid = 1'b1; end
            7'b1111000: begin dec_value = 4'd7; dec_valid = 1'b1; end
            7'b0000000: begin dec_value = 4'd8; dec_valid = 1'b1; end
            7'b0010000: begin dec_value = 4'd9; dec_valid = 1'b1; end
            7'b1111111: begin dec_value = 4'hF; dec_valid = 1'b0; end
            default:    begin dec_value = 4'hE; dec_valid = 1'b0; end
        endcase
    end

    // Outputs are registered on the edge that enters CAPTURE, so update is high
    // for exactly the one cycle spent in CAPTURE.
    assign capture_go = (state == ST_SETTLE) && !changed &&
                        (cnt >= CNT_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SETTLE;
        end else begin
            case (state)
                ST_SETTLE:  if (capture_go) state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_HOLD;
                ST_HOLD:    if (changed) state <= ST_SETTLE;
                default:    state <= ST_SETTLE;
            endcase
        end
    end

    // NOTE: the digit register file is reset explicitly because the captured
    // values are visible outputs with a defined power-on content (all 4'hF).
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_out  <= '1;
            digit_valid <= '0;
            update      <= 1'b0;
            upd_index   <= '0;
        end else begin
            update <= 1'b0;
            if (capture_go && one_hot) begin
                digits_out[4*int'(idx) +: 4] <= dec_value;
                digit_valid[idx]             <= dec_valid;
                upd_index                    <= idx;
                update                       <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_err <= 1'b0;
        end else if (capture_go && (!one_hot || dec_value == 4'hE)) begin
            pattern_err <= 1'b1;
        end
    end
`else
    assign pattern_err = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed self-checking bench for seven_seg_capture: reset, steady capture,
// glitch rejection, full scan, bad bus and reset during settle.
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits_out;
    logic [7:0]  digit_valid;
    logic        update;
    logic [2:0]  upd_index;
    logic        pattern_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_pulse_cyc = -1;

    logic [6:0] seg_tab [10];

    seven_seg_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .update      (update),
        .upd_index   (upd_index),
        .pattern_err (pattern_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (update === 1'b1) begin
            pulses         <= pulses + 1;
            last_pulse_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Changes the pins just after an edge; e0 is the cycle index of the next edge.
    task automatic set_pins(input logic [7:0] an_v, input logic [6:0] seg_v, output int e0);
        @(posedge clk);
        #1;
        an  = an_v;
        seg = seg_v;
        e0  = cyc + 1;
    endtask

    initial begin
        int e0;
        int p0;
        logic exp_err;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst = 1'b1;
        an  = 8'hFF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_digits", digits_out, 32'hFFFFFFFF);
        check("rst_valid", {24'd0, digit_valid}, 32'd0);
        check("rst_update", {31'd0, update}, 32'd0);
        check("rst_index", {29'd0, upd_index}, 32'd0);
        check("rst_err", {31'd0, pattern_err}, 32'd0);
        repeat (12) @(posedge clk);

        // Steady capture of digit 2 at position 2
        p0 = pulses;
        set_pins(8'b11111011, 7'b0100100, e0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("steady_pulses", pulses - p0, 1);
        check("steady_latency", last_pulse_cyc - e0, 6);
        check("steady_digit", {28'd0, digits_out[11:8]}, 32'd2);
        check("steady_valid", {31'd0, digit_valid[2]}, 32'd1);
        check("steady_index", {29'd0, upd_index}, 32'd2);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("steady_no_repeat", pulses - p0, 1);
        check("steady_update_low", {31'd0, update}, 32'd0);

        // Three-sample glitch to 8, then back to 2
        p0 = pulses;
        set_pins(8'b11111011, 7'b0000000, e0);
        repeat (2) @(posedge clk);
        set_pins(8'b11111011, 7'b0100100, e0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_pulses", pulses - p0, 1);
        check("glitch_digit", {28'd0, digits_out[11:8]}, 32'd2);
        check("glitch_index", {29'd0, upd_index}, 32'd2);

        // Scan positions 0..7 with digits 0..7
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            set_pins(~(8'b1 << i), seg_tab[i], e0);
            repeat (9) @(posedge clk);
        end
        @(negedge clk);
        check("scan_pulses", pulses - p0, 8);
        check("scan_digits", digits_out, 32'h76543210);
        check("scan_valid", {24'd0, digit_valid}, 32'hFF);
        check("scan_index", {29'd0, upd_index}, 32'd7);

        // Two anodes active at once
        p0 = pulses;
        set_pins(8'b11111100, seg_tab[5], e0);
        repeat (10) @(posedge clk);
        @(negedge clk);
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("bad_an_pulses", pulses - p0, 0);
        check("bad_an_err", {31'd0, pattern_err}, {31'd0, exp_err});
        check("bad_an_digits", digits_out, 32'h76543210);

        // Unknown segment pattern at position 0
        set_pins(8'b11111110, 7'b0101010, e0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bad_seg_pulses", pulses - p0, 1);
        check("bad_seg_digit", {28'd0, digits_out[3:0]}, 32'hE);
        check("bad_seg_valid", {31'd0, digit_valid[0]}, 32'd0);
        check("bad_seg_all", digits_out, 32'h7654321E);
        check("bad_seg_index", {29'd0, upd_index}, 32'd0);

        // Reset asserted three cycles into a settle period
        p0 = pulses;
        set_pins(8'b11110111, seg_tab[3], e0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_digits", digits_out, 32'hFFFFFFFF);
        check("midrst_valid", {24'd0, digit_valid}, 32'd0);
        check("midrst_update", {31'd0, update}, 32'd0);
        check("midrst_index", {29'd0, upd_index}, 32'd0);
        check("midrst_err", {31'd0, pattern_err}, 32'd0);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
